// File: rtl/aram_arbiter.sv
// aram_arbiter: shares the single-ported 64 KiB ARAM between the DSP (fixed priority) and the SPC700 CPU (bounded wait).
// Ports: clock/reset (async, active-low); dsp_* and cpu_* request bundles (req, we, addr, wdata) with
// combinational gnt and registered rvalid plus passthrough rdata; ram_* drives the synchronous ARAM macro.
// Optional ARAM_ARB_STATS_EN adds cpu_stall_count and forced_grant_count (16-bit, saturating).
module aram_arbiter #(
  parameter int MAX_WAIT = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dsp_req,
  input  logic        dsp_we,
  input  logic [15:0] dsp_addr,
  input  logic [7:0]  dsp_wdata,
  output logic        dsp_gnt,
  output logic        dsp_rvalid,
  output logic [7:0]  dsp_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] ram_address,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata
`ifdef ARAM_ARB_STATS_EN
  ,
  output logic [15:0] cpu_stall_count,
  output logic [15:0] forced_grant_count
`endif
);
  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       rd_valid_q, rd_valid_d;
  logic       rd_owner_q, rd_owner_d;
  logic       force_c;
  always_comb begin
    force_c     = dsp_req & cpu_req & (wait_cnt_q == MAX_W);
    dsp_gnt     = reset & dsp_req & ~force_c;
    cpu_gnt     = reset & cpu_req & (~dsp_req | force_c);
    ram_address = dsp_gnt ? dsp_addr : cpu_gnt ? cpu_addr : 16'h0;
    ram_wdata   = dsp_gnt ? dsp_wdata : cpu_gnt ? cpu_wdata : 8'h0;
    ram_we      = (dsp_gnt & dsp_we) | (cpu_gnt & cpu_we);
    wait_cnt_d  = cpu_gnt ? 8'h0 : (cpu_req & dsp_gnt & (wait_cnt_q < MAX_W)) ? wait_cnt_q + 8'h1 : wait_cnt_q;
    rd_valid_d  = (dsp_gnt & ~dsp_we) | (cpu_gnt & ~cpu_we);
    // tag stays put across idle/write cycles; only a read grant retargets it (0 = DSP, 1 = CPU)
    rd_owner_d  = (cpu_gnt & ~cpu_we) ? 1'b1 : (dsp_gnt & ~dsp_we) ? 1'b0 : rd_owner_q;
    dsp_rvalid  = rd_valid_q & ~rd_owner_q;
    cpu_rvalid  = rd_valid_q & rd_owner_q;
    dsp_rdata   = ram_rdata;
    cpu_rdata   = ram_rdata;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= 8'h0;
      rd_valid_q <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_owner_q <= rd_owner_d;
    end
  end
`ifdef ARAM_ARB_STATS_EN
  logic [15:0] stall_q, stall_d, forced_q, forced_d;
  always_comb begin
    stall_d  = (cpu_req & ~cpu_gnt & (stall_q != 16'hFFFF)) ? stall_q + 16'h1 : stall_q;
    forced_d = (cpu_gnt & force_c & (forced_q != 16'hFFFF)) ? forced_q + 16'h1 : forced_q;
    cpu_stall_count    = stall_q;
    forced_grant_count = forced_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q  <= 16'h0;
      forced_q <= 16'h0;
    end else begin
      stall_q  <= stall_d;
      forced_q <= forced_d;
    end
  end
`endif
endmodule

// File: tb/tb_aram_arbiter.sv
// tb_aram_arbiter: directed checks of aram_arbiter against a synchronous ARAM model.
module tb_aram_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        dsp_req = 1'b0, dsp_we = 1'b0;
  logic [15:0] dsp_addr = 16'h0;
  logic [7:0]  dsp_wdata = 8'h0;
  logic        dsp_gnt, dsp_rvalid;
  logic [7:0]  dsp_rdata;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_wdata = 8'h0;
  logic        cpu_gnt, cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic [15:0] ram_address;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic [7:0]  mem [0:65535];
  int total = 0;
  int bad = 0;
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (ram_we) mem[ram_address] <= ram_wdata;
    ram_rdata <= mem[ram_address];
  end
`ifdef ARAM_ARB_STATS_EN
  logic [15:0] cpu_stall_count, forced_grant_count;
  logic        sat_run = 1'b0;
  logic        s_dg, s_dv, s_cg, s_cv, s_we;
  logic [7:0]  s_dr, s_cr, s_wd;
  logic [15:0] s_ad, s_stall, s_forced;
  aram_arbiter #(.MAX_WAIT(255)) u_sat (
    .clock(clock), .reset(reset),
    .dsp_req(sat_run), .dsp_we(1'b0), .dsp_addr(16'h0), .dsp_wdata(8'h0),
    .dsp_gnt(s_dg), .dsp_rvalid(s_dv), .dsp_rdata(s_dr),
    .cpu_req(sat_run), .cpu_we(1'b0), .cpu_addr(16'h1), .cpu_wdata(8'h0),
    .cpu_gnt(s_cg), .cpu_rvalid(s_cv), .cpu_rdata(s_cr),
    .ram_address(s_ad), .ram_wdata(s_wd), .ram_we(s_we), .ram_rdata(8'h0),
    .cpu_stall_count(s_stall), .forced_grant_count(s_forced)
  );
`endif
  aram_arbiter #(.MAX_WAIT(3)) dut (
    .clock(clock), .reset(reset),
    .dsp_req(dsp_req), .dsp_we(dsp_we), .dsp_addr(dsp_addr), .dsp_wdata(dsp_wdata),
    .dsp_gnt(dsp_gnt), .dsp_rvalid(dsp_rvalid), .dsp_rdata(dsp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ram_address(ram_address), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
`ifdef ARAM_ARB_STATS_EN
    ,
    .cpu_stall_count(cpu_stall_count), .forced_grant_count(forced_grant_count)
`endif
  );
  task automatic test_reset;
    @(negedge clock);
    dsp_req = 1'b1; cpu_req = 1'b1; dsp_addr = 16'h1111; cpu_addr = 16'h2222;
    dsp_we = 1'b1; dsp_wdata = 8'h77;
    #1;
    total++;
    if ({dsp_gnt, cpu_gnt, dsp_rvalid, cpu_rvalid, ram_we} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000", {dsp_gnt, cpu_gnt, dsp_rvalid, cpu_rvalid, ram_we});
    end
    total++;
    if ({ram_address, ram_wdata} !== 24'h0) begin
      bad++; $display("FAIL reset_ram got=%h want=000000", {ram_address, ram_wdata});
    end
`ifdef ARAM_ARB_STATS_EN
    total++;
    if ({cpu_stall_count, forced_grant_count} !== 32'h0) begin
      bad++; $display("FAIL reset_stats got=%h want=0", {cpu_stall_count, forced_grant_count});
    end
`endif
    @(negedge clock);
    dsp_req = 1'b0; cpu_req = 1'b0; dsp_we = 1'b0; dsp_wdata = 8'h0;
    reset = 1'b1;
    #1;
    total++;
    if ({dsp_gnt, cpu_gnt, ram_we, ram_address} !== 19'h0) begin
      bad++; $display("FAIL idle_after_reset got=%h want=0", {dsp_gnt, cpu_gnt, ram_we, ram_address});
    end
  endtask
  task automatic test_cpu_read;
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    #1;
    total++;
    if ({cpu_gnt, dsp_gnt, ram_we, ram_address} !== {3'b100, 16'h1234}) begin
      bad++; $display("FAIL cpu_read_gnt got=%h want=%h", {cpu_gnt, dsp_gnt, ram_we, ram_address}, {3'b100, 16'h1234});
    end
    @(negedge clock);
    cpu_req = 1'b0;
    #1;
    total++;
    if ({cpu_rvalid, dsp_rvalid, cpu_rdata} !== {2'b10, 8'hA5}) begin
      bad++; $display("FAIL cpu_read_data got=%h want=%h", {cpu_rvalid, dsp_rvalid, cpu_rdata}, {2'b10, 8'hA5});
    end
    @(negedge clock);
    #1;
    total++;
    if ({cpu_rvalid, dsp_rvalid} !== 2'b00) begin
      bad++; $display("FAIL cpu_read_pulse got=%b want=00", {cpu_rvalid, dsp_rvalid});
    end
  endtask
  task automatic test_contention;
    logic prev_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      dsp_req = 1'b1; dsp_we = 1'b0; dsp_addr = 16'h1234;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
      #1;
      total++;
      if ({dsp_gnt, cpu_gnt} !== ((i % 4 == 3) ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL contend_gnt cycle=%0d got=%b want=%b", i, {dsp_gnt, cpu_gnt}, (i % 4 == 3) ? 2'b01 : 2'b10);
      end
      if (i > 0) begin
        total++;
        if ({dsp_rvalid, cpu_rvalid} !== {~prev_c, prev_c}) begin
          bad++; $display("FAIL contend_rvalid cycle=%0d got=%b want=%b", i, {dsp_rvalid, cpu_rvalid}, {~prev_c, prev_c});
        end
      end
`ifdef ARAM_ARB_STATS_EN
      if (i == 4) begin
        total++;
        if ({cpu_stall_count, forced_grant_count} !== {16'd3, 16'd1}) begin
          bad++; $display("FAIL contend_stats got=%h want=%h", {cpu_stall_count, forced_grant_count}, {16'd3, 16'd1});
        end
      end
`endif
      prev_c = (i % 4 == 3);
    end
    @(negedge clock);
    dsp_req = 1'b0; cpu_req = 1'b0;
  endtask
  task automatic test_write_then_read;
    @(negedge clock);
    dsp_req = 1'b1; dsp_we = 1'b1; dsp_addr = 16'h00FF; dsp_wdata = 8'h5A;
    #1;
    total++;
    if ({dsp_gnt, ram_we, ram_address, ram_wdata} !== {2'b11, 16'h00FF, 8'h5A}) begin
      bad++; $display("FAIL dsp_write got=%h want=%h", {dsp_gnt, ram_we, ram_address, ram_wdata}, {2'b11, 16'h00FF, 8'h5A});
    end
    @(negedge clock);
    dsp_req = 1'b0; dsp_we = 1'b0; dsp_wdata = 8'h0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h00FF;
    #1;
    total++;
    if ({cpu_gnt, ram_we, dsp_rvalid, cpu_rvalid} !== 4'b1000) begin
      bad++; $display("FAIL read_after_write_gnt got=%b want=1000", {cpu_gnt, ram_we, dsp_rvalid, cpu_rvalid});
    end
    @(negedge clock);
    cpu_req = 1'b0;
    #1;
    total++;
    if ({cpu_rvalid, ram_we, cpu_rdata} !== {2'b10, 8'h5A}) begin
      bad++; $display("FAIL read_after_write_data got=%h want=%h", {cpu_rvalid, ram_we, cpu_rdata}, {2'b10, 8'h5A});
    end
  endtask
  task automatic test_dsp_only;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      dsp_req = 1'b1; dsp_we = 1'b0; dsp_addr = 16'(i);
      #1;
      total++;
      if ({dsp_gnt, cpu_gnt, ram_address} !== {2'b10, 16'(i)}) begin
        bad++; $display("FAIL dsp_only cycle=%0d got=%h want=%h", i, {dsp_gnt, cpu_gnt, ram_address}, {2'b10, 16'(i)});
      end
    end
    // a fresh contention run must still take the full three DSP wins, so the counter held at 0
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      cpu_req = 1'b1; cpu_addr = 16'h1234;
      #1;
      total++;
      if ({dsp_gnt, cpu_gnt} !== ((i == 3) ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL wait_held cycle=%0d got=%b want=%b", i, {dsp_gnt, cpu_gnt}, (i == 3) ? 2'b01 : 2'b10);
      end
    end
    @(negedge clock);
    dsp_req = 1'b0; cpu_addr = 16'hBEEF;
    #1;
    total++;
    if ({dsp_gnt, cpu_gnt, ram_address} !== {2'b01, 16'hBEEF}) begin
      bad++; $display("FAIL cpu_immediate got=%h want=%h", {dsp_gnt, cpu_gnt, ram_address}, {2'b01, 16'hBEEF});
    end
    @(negedge clock);
    cpu_req = 1'b0;
  endtask
  task automatic test_reset_mid_read;
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    #1;
    total++;
    if (cpu_gnt !== 1'b1) begin
      bad++; $display("FAIL mid_reset_gnt got=%b want=1", cpu_gnt);
    end
    #2;
    reset = 1'b0; dsp_req = 1'b1;
    #1;
    total++;
    if ({dsp_gnt, cpu_gnt, ram_we, ram_address, ram_wdata} !== 27'h0) begin
      bad++; $display("FAIL mid_reset_outputs got=%h want=0", {dsp_gnt, cpu_gnt, ram_we, ram_address, ram_wdata});
    end
    repeat (2) begin
      @(negedge clock);
      #1;
      total++;
      if ({cpu_rvalid, dsp_rvalid, cpu_gnt, dsp_gnt} !== 4'b0) begin
        bad++; $display("FAIL mid_reset_rvalid got=%b want=0000", {cpu_rvalid, dsp_rvalid, cpu_gnt, dsp_gnt});
      end
    end
    @(negedge clock);
    reset = 1'b1; dsp_req = 1'b0; cpu_addr = 16'h00FF;
    #1;
    total++;
    if ({cpu_rvalid, cpu_gnt} !== 2'b01) begin
      bad++; $display("FAIL post_reset_gnt got=%b want=01", {cpu_rvalid, cpu_gnt});
    end
    @(negedge clock);
    cpu_req = 1'b0;
    #1;
    total++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h5A}) begin
      bad++; $display("FAIL post_reset_read got=%h want=%h", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h5A});
    end
  endtask
`ifdef ARAM_ARB_STATS_EN
  task automatic test_stall_saturation;
    @(negedge clock);
    sat_run = 1'b1;
    repeat (70000) @(negedge clock);
    sat_run = 1'b0;
    #1;
    total++;
    if (s_stall !== 16'hFFFF) begin
      bad++; $display("FAIL stall_saturate got=%h want=ffff", s_stall);
    end
    total++;
    if (s_forced !== 16'd273) begin
      bad++; $display("FAIL sat_forced got=%0d want=273", s_forced);
    end
  endtask
`endif
  initial begin
    mem[16'h1234] = 8'hA5;
    test_reset;
    test_cpu_read;
    test_contention;
    test_write_then_read;
    test_dsp_only;
    test_reset_mid_read;
`ifdef ARAM_ARB_STATS_EN
    test_stall_saturation;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aram_arbiter.md
# aram_arbiter

Two-port arbiter sharing the single-ported 64 KiB audio RAM (ARAM) between the DSP voice/echo engine and the SPC700 CPU bus. The DSP has fixed priority, and a bounded-wait counter guarantees the CPU a slot. The block sits between the DSP's `ram_*` pins, the CPU memory interface and the synchronous ARAM macro. It owns all RAM address, write-enable and write-data muxing.

## Interface
Parameters:
- `MAX_WAIT`, default 7: contended cycles a pending CPU request may lose before it is force-granted. Legal range 1..255.

Ports:
- `clock` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-low reset.
- `dsp_req` in 1: DSP access request.
- `dsp_we` in 1: request is a write.
- `dsp_addr` in 16: DSP address.
- `dsp_wdata` in 8: DSP write data.
- `dsp_gnt` out 1: combinational; DSP request accepted this cycle.
- `dsp_rvalid` out 1: registered; DSP read data valid.
- `dsp_rdata` out 8: DSP read data.
- `cpu_req`, `cpu_we`, `cpu_addr[15:0]`, `cpu_wdata[7:0]` in: CPU request bundle, same meaning as the DSP bundle.
- `cpu_gnt` out 1, `cpu_rvalid` out 1, `cpu_rdata` out 8: CPU return path, same meaning as the DSP return path.
- `ram_address` out 16: ARAM address.
- `ram_wdata` out 8: ARAM write data.
- `ram_we` out 1: ARAM write enable.
- `ram_rdata` in 8: ARAM read data, valid one cycle after the address is presented.
- `cpu_stall_count` out 16, `forced_grant_count` out 16: present only with `ARAM_ARB_STATS_EN`.

## Operation
- Exactly one grant per cycle at most. Owner selection:
  - Only one requester active: that requester wins.
  - Both active and `wait_cnt < MAX_WAIT`: DSP wins and `wait_cnt` increments.
  - Both active and `wait_cnt == MAX_WAIT`: CPU wins (forced grant).
  - Neither active: idle. `ram_address` = 0, `ram_we` = 0, `ram_wdata` = 0.
- `wait_cnt` (8 bit) clears on any CPU grant. It holds when the CPU is not requesting. It never exceeds `MAX_WAIT`.
- Granted bundle drives the RAM combinationally: `ram_address`, `ram_wdata`, and `ram_we` = granted `we`.
- Request handshake:
  - Requester holds `req`/`we`/`addr`/`wdata` stable until the clock edge at which `gnt` = 1.
  - Requester may present a new request, or drop `req`, immediately after that edge.
  - Throughput is one access per cycle per requester when uncontended.
- Reads: the `rvalid` of the granted port pulses one cycle after the grant.
  - `rdata` = `ram_rdata` during that cycle. It is a passthrough and is only meaningful while `rvalid` = 1.
- Writes: no `rvalid`. The write commits at the grant edge.
  - A read granted in any later cycle returns the new value.
- A 1-bit registered `rd_owner` tag records which port receives the next `ram_rdata`. It steers `rvalid`.
- `gnt` outputs are forced 0 while reset is asserted.

## Timing
- Grant latency 0 cycles, combinational from `req`. Read data latency 1 cycle after grant.
- Worst-case CPU wait under continuous DSP requests: `MAX_WAIT` cycles, with the grant on cycle `MAX_WAIT`+1.
- Reset values: `dsp_gnt`/`cpu_gnt` = 0, `dsp_rvalid`/`cpu_rvalid` = 0, `ram_we` = 0, `ram_address` = 0, `ram_wdata` = 0, `wait_cnt` = 0, `rd_owner` = DSP.
  - Stats counters reset to 0 when compiled in.
- Reset asserted mid-read, between grant and `rvalid`: the `rvalid` pulse is suppressed and is not replayed after release.
- Reset release: arbitration resumes on the first clock edge with `reset` high.
- Simultaneous read on one port and write on the other: only the winner's access occurs. The loser retries by holding `req`.
- Address wrap: none. The full 16-bit space maps directly to the RAM.

## Configuration
- `ARAM_ARB_STATS_EN` defined:
  - `cpu_stall_count` increments each cycle `cpu_req` = 1 and `cpu_gnt` = 0.
  - `forced_grant_count` increments on each forced CPU grant.
  - Both counters are 16-bit and saturate at 0xFFFF.
- `ARAM_ARB_STATS_EN` undefined:
  - Both ports and both counters are absent.
  - Arbitration behaviour is identical.

## Test plan
- ARAM[0x1234] = 0xA5; CPU-only read of 0x1234 -> `cpu_gnt` = 1 the same cycle; `cpu_rvalid` = 1 with `cpu_rdata` = 0xA5 the next cycle; `dsp_rvalid` stays 0.
- `MAX_WAIT` = 3; both ports request reads continuously -> grant pattern D,D,D,C repeating; `forced_grant_count` = 1 after the first C; `cpu_stall_count` = 3 at that point.
- DSP write 0x00FF <= 0x5A, then a CPU read of 0x00FF in the next cycle -> `cpu_rdata` = 0x5A; `ram_we` = 1 only in the write cycle.
- DSP requests only, CPU idle for 20 cycles -> DSP granted every cycle; `wait_cnt` stays 0; CPU then requests with DSP idle -> CPU granted immediately.
- Assert `reset` the cycle after a CPU read grant -> no `cpu_rvalid`; all outputs 0 during reset; after release a new read completes normally.
- With `ARAM_ARB_STATS_EN`, hold the CPU starved for 70000 cycles with `MAX_WAIT` = 255 -> `cpu_stall_count` saturates at 0xFFFF with no wrap.
